// File: rtl/mem_bank.sv
// mem_bank: DEPTH x DATA_W register bank, registered read port,
// bulk-clear and scan-out sequencer.
module mem_bank #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_req,
  input  logic              scan_req,
  output logic              busy,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic              scan_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic wr_ok;
  logic rd_in;
  logic at_last;

  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in   = {1'b0, rd_addr} < DEPTH_X;
  assign at_last = idx_q == LAST;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mem_d      = mem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    hold_d     = hold_q;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (wr_ok) begin
          mem_d[wr_addr] = wr_data;
        end
        // Read after the write update gives write-first forwarding.
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_in ? mem_d[rd_addr] : '0;
        end
        if (clear_req) begin
          state_d = CLEAR;
        end else if (scan_req) begin
          state_d = SCAN;
        end
      end
      CLEAR: begin
        mem_d[idx_q] = '0;
        if (at_last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SCAN: begin
        hold_d = mem_q[idx_q];
        if (at_last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      hold_q     <= hold_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = state_q != IDLE;
  assign scan_valid = state_q == SCAN;
  assign scan_last  = scan_valid && at_last;
  assign scan_data  = scan_valid ? mem_q[idx_q] : hold_q;

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: directed checks on a 4x2 bank, random checks
// on a 5x4 bank against a behavioural model.
module tb_mem_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 4 x 2 instance
  logic       a_we, a_re, a_cr, a_sr;
  logic [1:0] a_wa, a_wd, a_ra;
  logic [1:0] a_rd, a_sd;
  logic       a_rv, a_busy, a_sv, a_sl;

  mem_bank #(.DATA_W(2), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
    .rd_en(a_re), .rd_addr(a_ra),
    .rd_data(a_rd), .rd_valid(a_rv),
    .clear_req(a_cr), .scan_req(a_sr),
    .busy(a_busy), .scan_data(a_sd),
    .scan_valid(a_sv), .scan_last(a_sl)
  );

  // 5 x 4 instance
  logic       b_we, b_re, b_cr, b_sr;
  logic [2:0] b_wa, b_ra;
  logic [3:0] b_wd, b_rd, b_sd;
  logic       b_rv, b_busy, b_sv, b_sl;

  mem_bank #(.DATA_W(4), .DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
    .rd_en(b_re), .rd_addr(b_ra),
    .rd_data(b_rd), .rd_valid(b_rv),
    .clear_req(b_cr), .scan_req(b_sr),
    .busy(b_busy), .scan_data(b_sd),
    .scan_valid(b_sv), .scan_last(b_sl)
  );

  task automatic a_idle();
    a_we = 0; a_re = 0; a_cr = 0; a_sr = 0;
    a_wa = 0; a_wd = 0; a_ra = 0;
  endtask

  task automatic a_write(input int ad, input int d);
    a_we = 1; a_wa = 2'(ad); a_wd = 2'(d);
    tick();
    a_we = 0;
  endtask

  task automatic a_read(input string tag, input int ad, input int exp);
    a_re = 1; a_ra = 2'(ad);
    tick();
    a_re = 0;
    chk({tag, "_rv"}, int'(a_rv), 1);
    chk({tag, "_rd"}, int'(a_rd), exp);
  endtask

  task automatic a_fill();
    a_write(0, 1); a_write(1, 2); a_write(2, 3); a_write(3, 0);
  endtask

  // Behavioural model of the 5 x 4 bank
  int bm[5];
  int b_left = 0;
  bit b_scan = 0;
  int b_pos = 0;
  int b_rdm = 0;
  int b_rvm = 0;
  int b_hold = 0;

  task automatic b_cyc(input int we, input int wa, input int wd,
                       input int re, input int ra,
                       input int cr, input int sr);
    int sv;
    b_we = 1'(we); b_wa = 3'(wa); b_wd = 4'(wd);
    b_re = 1'(re); b_ra = 3'(ra);
    b_cr = 1'(cr); b_sr = 1'(sr);
    @(posedge clk);
    b_rvm = 0;
    if (b_left == 0) begin
      if (we != 0 && wa < 5) bm[wa] = wd;
      if (re != 0) begin
        b_rvm = 1;
        b_rdm = (ra < 5) ? bm[ra] : 0;
      end
      if (cr != 0) begin
        b_left = 5; b_scan = 0; b_pos = 0;
      end else if (sr != 0) begin
        b_left = 5; b_scan = 1; b_pos = 0;
      end
    end else begin
      if (b_scan) b_hold = bm[b_pos];
      else bm[b_pos] = 0;
      b_pos++;
      b_left--;
    end
    #1;
    sv = (b_left > 0 && b_scan) ? 1 : 0;
    chk("b_busy", int'(b_busy), (b_left > 0) ? 1 : 0);
    chk("b_rv", int'(b_rv), b_rvm);
    chk("b_rd", int'(b_rd), b_rdm);
    chk("b_sv", int'(b_sv), sv);
    chk("b_sl", int'(b_sl), (sv == 1 && b_pos == 4) ? 1 : 0);
    chk("b_sd", int'(b_sd), sv == 1 ? bm[b_pos] : b_hold);
    b_we = 0; b_re = 0; b_cr = 0; b_sr = 0;
  endtask

  initial begin
    int exp_sd[4];
    exp_sd[0] = 1; exp_sd[1] = 2; exp_sd[2] = 3; exp_sd[3] = 0;
    a_idle();
    b_we = 0; b_re = 0; b_cr = 0; b_sr = 0;
    b_wa = 0; b_wd = 0; b_ra = 0;
    for (int i = 0; i < 5; i++) bm[i] = 0;

    #3;
    chk("rst_rd", int'(a_rd), 0);
    chk("rst_rv", int'(a_rv), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_sv", int'(a_sv), 0);
    chk("rst_sd", int'(a_sd), 0);
    chk("rst_sl", int'(a_sl), 0);
    @(negedge clk);
    rst_n = 1;

    // Test 1
    a_fill();
    a_read("t1", 2, 3);
    tick();
    chk("t1_rv_pulse", int'(a_rv), 0);
    chk("t1_rd_hold", int'(a_rd), 3);

    // Test 2: write-first
    a_we = 1; a_wa = 1; a_wd = 3;
    a_re = 1; a_ra = 1;
    tick();
    a_idle();
    chk("t2_rd", int'(a_rd), 3);
    a_read("t2_addr3", 3, 0);

    // Test 3: scan
    a_fill();
    a_sr = 1;
    tick();
    a_sr = 0;
    for (int k = 0; k < 4; k++) begin
      chk("t3_busy", int'(a_busy), 1);
      chk("t3_sv", int'(a_sv), 1);
      chk("t3_sd", int'(a_sd), exp_sd[k]);
      chk("t3_sl", int'(a_sl), (k == 3) ? 1 : 0);
      if (k > 1) chk("t3_rv_busy", int'(a_rv), 0);
      if (k == 1) begin
        a_we = 1; a_wa = 0; a_wd = 3;
        a_re = 1; a_ra = 0;
        a_sr = 1;
      end
      tick();
      a_idle();
    end
    chk("t3_busy_end", int'(a_busy), 0);
    chk("t3_sv_end", int'(a_sv), 0);
    chk("t3_sd_hold", int'(a_sd), 0);
    a_read("t3_unchanged", 0, 1);

    // Test 4: clear wins over scan
    a_fill();
    a_cr = 1; a_sr = 1;
    tick();
    a_idle();
    for (int k = 0; k < 4; k++) begin
      chk("t4_busy", int'(a_busy), 1);
      chk("t4_sv", int'(a_sv), 0);
      tick();
    end
    chk("t4_busy_end", int'(a_busy), 0);
    for (int i = 0; i < 4; i++) a_read("t4_zero", i, 0);

    // Random traffic on the 5-entry bank
    for (int n = 0; n < 400; n++) begin
      b_cyc($urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 7), ($urandom_range(0, 39) == 0) ? 1 : 0,
            ($urandom_range(0, 19) == 0) ? 1 : 0);
    end
    for (int n = 0; n < 6; n++) b_cyc(0, 0, 0, 0, 0, 0, 0);

    // Test 5: DEPTH=5, DATA_W=4
    for (int i = 0; i < 4; i++) b_cyc(1, i, i + 1, 0, 0, 0, 0);
    b_cyc(1, 4, 10, 0, 0, 0, 0);
    b_cyc(1, 6, 15, 0, 0, 0, 0);
    b_cyc(0, 0, 0, 1, 4, 0, 0);
    chk("t5_rd4", int'(b_rd), 10);
    b_cyc(0, 0, 0, 1, 6, 0, 0);
    chk("t5_rd6", int'(b_rd), 0);
    chk("t5_rv6", int'(b_rv), 1);
    b_cyc(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t5_sv", int'(b_sv), 1);
      chk("t5_sd", int'(b_sd), (k == 4) ? 10 : k + 1);
      chk("t5_sl", int'(b_sl), (k == 4) ? 1 : 0);
      b_cyc(0, 0, 0, 0, 0, 0, 0);
    end
    chk("t5_sv_end", int'(b_sv), 0);

    // Test 6: async reset mid-scan
    a_fill();
    a_sr = 1;
    tick();
    a_idle();
    tick();
    tick();
    chk("t6_beat2", int'(a_sd), 3);
    #2;
    rst_n = 0;
    #1;
    chk("t6_busy", int'(a_busy), 0);
    chk("t6_sv", int'(a_sv), 0);
    chk("t6_rv", int'(a_rv), 0);
    chk("t6_sd", int'(a_sd), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) a_read("t6_zero", i, 0);
    a_sr = 1;
    tick();
    a_idle();
    chk("t6_rescan_busy", int'(a_busy), 1);
    chk("t6_rescan_sv", int'(a_sv), 1);
    for (int k = 0; k < 4; k++) tick();
    chk("t6_idle", int'(a_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
